// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky overflow/underflow.
// Define FWFT_EN for first-word-fall-through reads; default build registers R_data.
module sync_fifo_flags #(
    parameter int  DATA_WIDTH = 8,
    parameter int  DEPTH      = 8,
    parameter int  AF_LEVEL   = DEPTH - 2,
    parameter int  AE_LEVEL   = 2,
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_inc,
    input  logic [DATA_WIDTH-1:0] W_data,
    input  logic                  R_inc,
    output logic [DATA_WIDTH-1:0] R_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Explicit wrap keeps non-power-of-two depths exact.
    function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign full         = (count == CNT_WIDTH'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_WIDTH'(AF_LEVEL));
    assign almost_empty = (count <= CNT_WIDTH'(AE_LEVEL));

    assign wr_acc = W_inc && !full;
    assign rd_acc = R_inc && !empty;

    always_ff @(posedge CLK) begin
        if (wr_acc)
            mem[wr_ptr] <= W_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= ptr_next(wr_ptr);
            if (rd_acc)
                rd_ptr <= ptr_next(rd_ptr);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (W_inc && full)
                overflow <= 1'b1;
            if (R_inc && empty)
                underflow <= 1'b1;
        end
    end

`ifdef FWFT_EN
    assign R_data = mem[rd_ptr];
`else
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            R_data <= '0;
        else if (rd_acc)
            R_data <= mem[rd_ptr];
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: an 8-deep instance and a 6-deep instance for wrap.
module tb_sync_fifo_flags;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       W_inc = 1'b0;
    logic [7:0] W_data = '0;
    logic       R_inc = 1'b0;
    logic [7:0] R_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    logic       W_inc6 = 1'b0;
    logic [7:0] W_data6 = '0;
    logic       R_inc6 = 1'b0;
    logic [7:0] R_data6;
    logic       full6, empty6, almost_full6, almost_empty6, overflow6, underflow6;
    logic [2:0] count6;

    int checks = 0;
    int failures = 0;

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(8)) u_dut (
        .CLK(CLK), .RST(RST), .W_inc(W_inc), .W_data(W_data), .R_inc(R_inc),
        .R_data(R_data), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(6)) u_dut6 (
        .CLK(CLK), .RST(RST), .W_inc(W_inc6), .W_data(W_data6), .R_inc(R_inc6),
        .R_data(R_data6), .full(full6), .empty(empty6), .almost_full(almost_full6),
        .almost_empty(almost_empty6), .count(count6), .overflow(overflow6), .underflow(underflow6)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step8(input logic w, input logic [7:0] wd, input logic r);
        W_inc  = w;
        W_data = wd;
        R_inc  = r;
        @(posedge CLK);
        #1;
        W_inc = 1'b0;
        R_inc = 1'b0;
    endtask

    // Read with an expected word: head before the edge in FWFT, registered after it otherwise.
    task automatic pop8(input logic w, input logic [7:0] wd, input logic [7:0] exp, input string tag);
`ifdef FWFT_EN
        chk(tag, R_data, exp);
`endif
        step8(w, wd, 1'b1);
`ifndef FWFT_EN
        chk(tag, R_data, exp);
`endif
    endtask

    logic [7:0] q6[$];
    logic [7:0] nxt6;
    logic [7:0] exp6;
    logic       wa6, ra6, r6;

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
`ifndef FWFT_EN
        chk("rst_rdata", R_data, 0);
`endif

        step8(1'b0, 8'h00, 1'b1);
        chk("unf_set", underflow, 1);
        chk("unf_count", count, 0);
        chk("unf_empty", empty, 1);
`ifndef FWFT_EN
        chk("unf_rdata", R_data, 0);
`endif

        for (int i = 1; i <= 8; i++) begin
            step8(1'b1, 8'(i), 1'b0);
            chk("wr_count", count, i);
            chk("wr_afull", almost_full, (i >= 6));
            chk("wr_full", full, (i == 8));
            chk("wr_aempty", almost_empty, (i <= 2));
            chk("wr_empty", empty, 0);
        end
        chk("unf_sticky", underflow, 1);
        chk("ovf_before", overflow, 0);

        step8(1'b1, 8'hFF, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 8);
        chk("ovf_full", full, 1);

        for (int i = 1; i <= 8; i++) begin
            pop8(1'b0, 8'h00, 8'(i), "rd_order");
            chk("rd_count", count, 8 - i);
        end
        chk("rd_empty", empty, 1);
        chk("ovf_sticky", overflow, 1);

        for (int i = 0; i < 5; i++)
            step8(1'b1, 8'h30 + 8'(i), 1'b0);
        chk("burst_count", count, 5);
        #2 RST = 1'b1;
        #1;
        chk("async_count", count, 0);
        chk("async_empty", empty, 1);
        chk("async_aempty", almost_empty, 1);
        chk("async_ovf", overflow, 0);
        chk("async_unf", underflow, 0);
`ifndef FWFT_EN
        chk("async_rdata", R_data, 0);
`endif
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 3; i++)
            step8(1'b1, 8'h10 + 8'(i), 1'b0);
        chk("pre_same_count", count, 3);
        for (int k = 0; k < 10; k++) begin
            pop8(1'b1, 8'h13 + 8'(k), 8'h10 + 8'(k), "same_cyc_data");
            chk("same_cyc_count", count, 3);
        end
        for (int i = 0; i < 5; i++)
            step8(1'b1, 8'h1D + 8'(i), 1'b0);
        chk("fill_count", count, 8);
        chk("fill_full", full, 1);
        chk("fill_ovf", overflow, 0);

        pop8(1'b1, 8'hEE, 8'h1A, "full_both_data");
        chk("full_both_count", count, 7);
        chk("full_both_ovf", overflow, 1);
        chk("full_both_full", full, 0);
        for (int k = 0; k < 7; k++)
            pop8(1'b0, 8'h00, 8'h1B + 8'(k), "drain_data");
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);

        nxt6 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            W_inc6  = 1'b1;
            W_data6 = nxt6;
            @(posedge CLK);
            #1;
            W_inc6 = 1'b0;
            q6.push_back(nxt6);
            nxt6++;
        end
        chk("d6_prefill", count6, 4);
        for (int k = 0; k < 20; k++) begin
            r6  = (k % 4 != 0);
            wa6 = (q6.size() < 6);
            ra6 = r6 && (q6.size() > 0);
`ifdef FWFT_EN
            if (ra6)
                chk("d6_head", R_data6, q6[0]);
`endif
            W_inc6  = 1'b1;
            W_data6 = nxt6;
            R_inc6  = r6;
            @(posedge CLK);
            #1;
            W_inc6 = 1'b0;
            R_inc6 = 1'b0;
            if (ra6) begin
                exp6 = q6.pop_front();
`ifndef FWFT_EN
                chk("d6_order", R_data6, exp6);
`endif
            end
            if (wa6) begin
                q6.push_back(nxt6);
                nxt6++;
            end
            chk("d6_count", count6, q6.size());
            chk("d6_count_max", (count6 <= 3'd6), 1);
            chk("d6_full", full6, (q6.size() == 6));
        end

`ifdef FWFT_EN
        RST = 1'b1;
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;
        step8(1'b1, 8'hA5, 1'b0);
        chk("fwft_head", R_data, 8'hA5);
        chk("fwft_not_empty", empty, 0);
        step8(1'b0, 8'h00, 1'b1);
        chk("fwft_pop_empty", empty, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Single-clock, parametrised FIFO with arbitrary depth, an occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the same-clock counterpart of the dual-clock FIFO, for buffering between blocks inside one clock domain (e.g. the register-file-to-UART transmit path), where gray-coded pointer synchronisation is unnecessary. Memory, pointers, count and flags are contained in this one module.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 8, number of storage words; any integer ≥2, power of two not required
- AF_LEVEL, DEPTH-2, almost_full asserted when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserted when count ≤ AE_LEVEL (0..DEPTH-1)
- CNT_WIDTH (localparam), $clog2(DEPTH+1)
- CLK  input  1  sole clock; all state changes on rising edge
- RST  input  1  asynchronous, active-high reset
- W_inc  input  1  write request
- W_data  input  DATA_WIDTH  write word, sampled with W_inc
- R_inc  input  1  read request
- R_data  output  DATA_WIDTH  read word
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- count  output  CNT_WIDTH  current occupancy
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH×DATA_WIDTH register array; wr_ptr, rd_ptr each $clog2(DEPTH) bits, range 0..DEPTH-1.
- Pointer wrap: ptr == DEPTH-1 advances to 0 (explicit compare, not modulo-2^n), so non-power-of-two depth is exact.
- Write accepted: W_inc && !full → mem[wr_ptr] ← W_data, wr_ptr advances.
- Read accepted: R_inc && !empty → rd_ptr advances; R_data per Configuration.
- full/empty are evaluated on the state at the start of the cycle; a read in the same cycle does not unblock a write when full, and a write does not unblock a read when empty.
- count: +1 on write-only, −1 on read-only, unchanged if both or neither accepted. Never exceeds DEPTH or drops below 0.
- Flags: combinational decode of the count register; no other logic.
- Rejected write while full: memory, pointers and count unchanged; overflow ← 1. Rejected read while empty: state unchanged, R_data holds; underflow ← 1.
- overflow/underflow clear only on RST.
- Reset (asynchronous, any time including mid-transfer): wr_ptr=rd_ptr=0, count=0, R_data=0, overflow=underflow=0; so empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL ≥1). Memory contents are not reset.

## Timing
- Write-to-flag latency: count and all flags update at the edge that accepts the write; visible in the following cycle.
- Standard mode: R_data valid one cycle after the accepting R_inc edge; holds until the next accepted read.
- A word written at edge N is readable (R_inc honoured) from edge N+1 onward.
- Sustained throughput: one write and one read per cycle when 0 < count < DEPTH.

## Configuration
- FWFT_EN defined: first-word-fall-through; R_data = mem[rd_ptr] combinationally, so the head word is on R_data whenever empty=0, and R_inc pops it (the next word appears after the edge). R_data is don't-care while empty=1; the R_data register is not built.
- FWFT_EN undefined: standard mode described above, registered R_data, reset to 0.

## Test plan
- Reset then idle: empty=1, almost_empty=1, full=0, count=0, R_data=0, overflow=underflow=0.
- DEPTH=8: write 0x01..0x08 → count=8, full=1, almost_full set from count=6; a 9th write of 0xFF → overflow=1, count stays 8; read 8 → R_data 0x01..0x08 in order, empty=1.
- DEPTH=6 (non-power-of-two): 20 cycles of interleaved write/read of incrementing data → order preserved across pointer wrap 5→0, count never > 6.
- count=3, W_inc and R_inc same cycle ×10 → count stays 3, data order intact; at full with both asserted → read accepted, write rejected, overflow=1, count=7.
- Read when empty → underflow=1, R_data unchanged, count 0; assert RST mid-burst at count=5 → immediate count=0, empty=1, flags cleared.
- FWFT_EN build: single write of 0xA5 → R_data=0xA5 next cycle without R_inc; R_inc → empty=1.
